// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter for the hex display data bus.
// Counts on clk_div ticks while running, or on debounced step-button
// presses while paused. A run button toggles between the two modes.

// Button conditioner: synchroniser, debouncer and rising-edge detector.
module bcd_btn_cond #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic [1:0]       sync_ff;
    logic             level;
    logic             level_d;
    logic [DEB_W-1:0] deb_cnt;

    // Two-flop synchroniser brings the raw asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], btn};
        end
    end

    // The debounced level only follows the input after it differs for 2**DEB_W cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level   <= 1'b0;
        end else if (sync_ff[1] == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == '1) begin
            level   <= sync_ff[1];
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for press detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // A press is the single cycle where the debounced level has just risen.
    assign press = level & ~level_d;

endmodule

module bcd_counter4 #(
    parameter int DEB_W    = 16,
    parameter bit INIT_RUN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        dir,
    input  logic        clr,
    output logic [15:0] data,
    output logic        wrap,
    output logic        running
);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        run_press;
    logic        step_press;
    logic        step_en;
    logic [15:0] data_next;
    logic        carry_out;

    bcd_btn_cond #(.DEB_W(DEB_W)) u_run_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .press (run_press)
    );

    bcd_btn_cond #(.DEB_W(DEB_W)) u_step_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .press (step_press)
    );

    // Mode register; reset picks the mode selected by INIT_RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT_RUN ? RUN : PAUSE;
        end else begin
            state <= state_next;
        end
    end

    // Run-button presses flip the mode; the step source follows the current mode.
    always_comb begin
        state_next = state;
        step_en    = 1'b0;
        if (run_press) begin
            state_next = (state == RUN) ? PAUSE : RUN;
        end
        if (state == RUN) begin
            step_en = tick;
        end else begin
            step_en = step_press;
        end
    end

    // Ripple the increment or decrement through the digits; the final carry is the wrap.
    always_comb begin
        logic [3:0] digit;
        logic       carry;
        data_next = data;
        carry     = 1'b1;
        digit     = 4'd0;
        for (int i = 0; i < 4; i++) begin
            digit = data[4*i +: 4];
            if (carry) begin
                if (dir) begin
                    if (digit == 4'd9) begin
                        digit = 4'd0;
                    end else begin
                        digit = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        digit = 4'd9;
                    end else begin
                        digit = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            data_next[4*i +: 4] = digit;
        end
        carry_out = carry;
    end

    // Count register; clear beats any step, and wrap marks the cycle showing the wrapped value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= 16'h0000;
            wrap <= 1'b0;
        end else if (clr) begin
            data <= 16'h0000;
            wrap <= 1'b0;
        end else if (step_en) begin
            data <= data_next;
            wrap <= carry_out;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_bcd_counter4.sv
// Self-checking bench for bcd_counter4 against a decimal-integer reference model.
module tb_bcd_counter4;

    localparam int DEB_W = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        tick     = 1'b0;
    logic        btn_run  = 1'b0;
    logic        btn_step = 1'b0;
    logic        dir      = 1'b1;
    logic        clr      = 1'b0;
    logic [15:0] data;
    logic        wrap;
    logic        running;

    int test_count = 0;
    int fail_count = 0;

    // Reference model: the count as a plain integer 0..9999.
    int m_val  = 0;
    bit m_wrap = 1'b0;
    bit m_run  = 1'b1;

    bcd_counter4 #(.DEB_W(DEB_W), .INIT_RUN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .dir      (dir),
        .clr      (clr),
        .data     (data),
        .wrap     (wrap),
        .running  (running)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((v / 1000) % 10);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_data"}, 32'(data), 32'(toBcd(m_val)));
        checkOutput({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
        checkOutput({tag, "_running"}, 32'(running), 32'(m_run));
    endtask

    task automatic modelStep(input bit d);
        if (d) begin
            m_wrap = (m_val == 9999);
            m_val  = (m_val + 1) % 10000;
        end else begin
            m_wrap = (m_val == 0);
            m_val  = (m_val + 9999) % 10000;
        end
    endtask

    // One clock edge with the given tick/dir/clr, then compare against the model.
    task automatic applyStimulus(input bit t, input bit d, input bit c, input string tag);
        @(negedge clk);
        tick = t;
        dir  = d;
        clr  = c;
        @(posedge clk);
        if (c) begin
            m_val  = 0;
            m_wrap = 1'b0;
        end else if (m_run && t) begin
            modelStep(d);
        end else begin
            m_wrap = 1'b0;
        end
        #1;
        checkAll(tag);
    endtask

    // Hold a button long enough to pass the debouncer, release it, then check the outcome.
    task automatic pressButton(input bit is_run, input int hold, input bit rand_tick, input bit d, input string tag);
        for (int i = 0; i < hold + 40; i++) begin
            @(negedge clk);
            clr  = 1'b0;
            dir  = d;
            tick = rand_tick ? 1'($urandom_range(0, 1)) : 1'b0;
            if (is_run) btn_run = (i < hold);
            else        btn_step = (i < hold);
        end
        @(negedge clk);
        tick = 1'b0;
        if (is_run) begin
            m_run = ~m_run;
        end else if (!m_run) begin
            modelStep(d);
        end
        m_wrap = 1'b0;
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        // Asynchronous reset takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #2 checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, "idle");

        // Down wrap to reach 9998, then up through 9999 to the wrap at 0000.
        applyStimulus(1'b1, 1'b0, 1'b0, "dn_wrap0");
        applyStimulus(1'b1, 1'b0, 1'b0, "dn_9998");
        applyStimulus(1'b1, 1'b1, 1'b0, "up_9999");
        applyStimulus(1'b1, 1'b1, 1'b0, "up_wrap");
        applyStimulus(1'b0, 1'b1, 1'b0, "wrap_drop");

        // Multi-digit carries 0099->0100 and 0999->1000, then borrow 1000->0999.
        repeat (99) applyStimulus(1'b1, 1'b1, 1'b0, "up_to99");
        applyStimulus(1'b1, 1'b1, 1'b0, "up_100");
        applyStimulus(1'b0, 1'b1, 1'b1, "clr");
        repeat (999) applyStimulus(1'b1, 1'b1, 1'b0, "up_to999");
        applyStimulus(1'b1, 1'b1, 1'b0, "up_1000");
        applyStimulus(1'b1, 1'b0, 1'b0, "dn_0999");

        // Down wrap from 0001.
        applyStimulus(1'b0, 1'b1, 1'b1, "clr2");
        applyStimulus(1'b1, 1'b1, 1'b0, "up_0001");
        applyStimulus(1'b1, 1'b0, 1'b0, "dn_0000");
        applyStimulus(1'b1, 1'b0, 1'b0, "dn_wrap");

        // Clear wins over a simultaneous tick at 9999.
        applyStimulus(1'b1, 1'b1, 1'b1, "clr_pri");

        // Random ticks, directions and occasional clears while running.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 39) == 0), "rand_run");
        end

        // Pause, then ticks must be ignored.
        pressButton(1'b1, 40, 1'b0, 1'b1, "run_off");
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "pause_tick");
        end

        // Step presses in pause, with stray ticks alongside.
        pressButton(1'b0, 40, 1'b1, 1'b1, "step_up");
        pressButton(1'b0, 40, 1'b1, 1'b0, "step_dn");

        // A bouncing button never settles long enough to produce a press.
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                btn_step = (i < 3);
                tick     = 1'($urandom_range(0, 1));
            end
        end
        repeat (30) begin
            @(negedge clk);
            btn_step = 1'b0;
            tick     = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        tick = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, "bounce");

        // A very long hold still yields exactly one step.
        pressButton(1'b0, 1000, 1'b1, 1'b1, "long_hold");

        // Resume running; step presses are then ignored.
        pressButton(1'b1, 40, 1'b0, 1'b1, "run_on");
        pressButton(1'b0, 40, 1'b0, 1'b1, "step_in_run");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 29) == 0), "rand_run2");
        end

        // Reach 1234, pause, start a press, then reset asynchronously mid-debounce.
        applyStimulus(1'b0, 1'b1, 1'b1, "clr3");
        repeat (1234) applyStimulus(1'b1, 1'b1, 1'b0, "up_to1234");
        pressButton(1'b1, 40, 1'b0, 1'b1, "pause_1234");
        repeat (8) begin
            @(negedge clk);
            btn_step = 1'b1;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        m_val  = 0;
        m_wrap = 1'b0;
        m_run  = 1'b1;
        checkAll("async_rst");
        @(negedge clk);
        btn_step = 1'b0;
        rst_n    = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
